// File: rtl/connect4_defs_pkg.sv
// connect4_defs_pkg: board geometry, FSM encoding and player ids shared by the drop controller.
package connect4_defs_pkg;
    localparam int NUM_COLS  = 7;
    localparam int NUM_ROWS  = 6;
    localparam int MAX_MOVES = 42;
    localparam int COL_W     = 3;
    localparam int ROW_W     = 3;
    localparam int MOVE_W    = 6;
    localparam int COL_SLOTS = 1 << COL_W;
    localparam logic PLAYER1 = 1'b0;
    localparam logic PLAYER2 = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WRITE, S_DONE, S_REJECT} state_t;
    typedef logic [NUM_ROWS-1:0] col_vec_t;
endpackage

// File: rtl/column_drop_ctrl_column_stack.sv
// column_stack: occupancy thermometer and per-cell owner bits for one board column.
module column_stack
    import connect4_defs_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_resetn,
    input  logic     i_clear,
    input  logic     i_push,
    input  logic     i_player,
    output col_vec_t o_occ,
    output col_vec_t o_own,
    output logic     o_full
);
    col_vec_t r_occ;
    col_vec_t r_own;
    col_vec_t w_slot;
    // one-hot of the lowest empty cell, i.e. the cell a push fills
    assign w_slot = {r_occ[NUM_ROWS-2:0], 1'b1} & ~r_occ;
    always_ff @(posedge i_clk) begin
        if (!i_resetn || i_clear) begin
            r_occ <= '0;
            r_own <= '0;
        end else if (i_push && !o_full) begin
            r_occ <= {r_occ[NUM_ROWS-2:0], 1'b1};
            r_own <= (r_own & ~w_slot) | (w_slot & {NUM_ROWS{i_player}});
        end
    end
    assign o_occ  = r_occ;
    assign o_own  = r_own;
    assign o_full = r_occ[NUM_ROWS-1];
endmodule

// File: rtl/column_drop_ctrl.sv
// column_drop_ctrl: Connect Four drop FSM, turn and move tracking, and cell read port.
module column_drop_ctrl
    import connect4_defs_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_new_game,
    input  logic             i_drop_req,
    input  logic [COL_W-1:0] i_drop_col,
    output logic             o_busy,
    output logic             o_drop_done,
    output logic             o_drop_reject,
    output col_vec_t         o_onoff_val,
    output logic [COL_W-1:0] o_drop_col_out,
    output logic             o_piece_player,
    output logic             o_player,
    output logic             o_board_full,
    input  logic [COL_W-1:0] i_rd_col,
    input  logic [ROW_W-1:0] i_rd_row,
    output logic             o_rd_occupied,
    output logic             o_rd_player
);
    state_t              r_state;
    logic [COL_W-1:0]    r_col;
    logic [COL_W-1:0]    r_drop_col_out;
    logic [MOVE_W-1:0]   r_moves;
    col_vec_t            r_onoff;
    logic                r_busy;
    logic                r_done;
    logic                r_reject;
    logic                r_player;
    logic                r_piece_player;
    logic                r_board_full;
    col_vec_t            w_occ [COL_SLOTS];
    col_vec_t            w_own [COL_SLOTS];
    logic [COL_SLOTS-1:0] w_full;
    logic [(1<<ROW_W)-1:0] w_rd_occ;
    logic [(1<<ROW_W)-1:0] w_rd_own;

    // unused column codes look permanently full so CHECK rejects them
    for (genvar c = 0; c < COL_SLOTS; c++) begin : g_col
        if (c < NUM_COLS) begin : g_stack
            column_stack u_stack (
                .i_clk    (i_clk),
                .i_resetn (i_resetn),
                .i_clear  (i_new_game),
                .i_push   (r_state == S_WRITE && r_col == COL_W'(c)),
                .i_player (r_player),
                .o_occ    (w_occ[c]),
                .o_own    (w_own[c]),
                .o_full   (w_full[c])
            );
        end else begin : g_pad
            assign w_occ[c]  = '0;
            assign w_own[c]  = '0;
            assign w_full[c] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn || i_new_game) begin
            r_state        <= S_IDLE;
            r_col          <= '0;
            r_drop_col_out <= '0;
            r_moves        <= '0;
            r_onoff        <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_reject       <= 1'b0;
            r_player       <= PLAYER1;
            r_piece_player <= PLAYER1;
            r_board_full   <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_reject <= 1'b0;
            case (r_state)
                S_IDLE: if (i_drop_req) begin
                    r_col   <= i_drop_col;
                    r_busy  <= 1'b1;
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_reject <= w_full[r_col];
                    r_state  <= w_full[r_col] ? S_REJECT : S_WRITE;
                end
                S_WRITE: begin
                    r_moves        <= r_moves + MOVE_W'(1);
                    r_onoff        <= {w_occ[r_col][NUM_ROWS-2:0], 1'b1};
                    r_drop_col_out <= r_col;
                    r_piece_player <= r_player;
                    r_board_full   <= r_board_full | ((r_moves + MOVE_W'(1)) == MOVE_W'(MAX_MOVES));
                    r_done         <= 1'b1;
                    r_state        <= S_DONE;
                end
                S_DONE: begin
                    r_player <= (r_player == PLAYER1) ? PLAYER2 : PLAYER1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_drop_done    = r_done;
    assign o_drop_reject  = r_reject;
    assign o_onoff_val    = r_onoff;
    assign o_drop_col_out = r_drop_col_out;
    assign o_piece_player = r_piece_player;
    assign o_player       = r_player;
    assign o_board_full   = r_board_full;

    assign w_rd_occ      = {{((1<<ROW_W)-NUM_ROWS){1'b0}}, w_occ[i_rd_col]};
    assign w_rd_own      = {{((1<<ROW_W)-NUM_ROWS){1'b0}}, w_own[i_rd_col]};
    assign o_rd_occupied = w_rd_occ[i_rd_row];
    assign o_rd_player   = w_rd_occ[i_rd_row] & w_rd_own[i_rd_row];
endmodule

// File: tb/tb_column_drop_ctrl.sv
// tb_column_drop_ctrl: scenario tasks checked against a board model kept as column heights and owner grid.
module tb_column_drop_ctrl;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       new_game = 1'b0;
    logic       drop_req = 1'b0;
    logic [2:0] drop_col = '0;
    logic [2:0] rd_col = '0;
    logic [2:0] rd_row = '0;
    logic       busy, done, rej, pp, player, full, rd_occ, rd_pl;
    logic [5:0] onoff;
    logic [2:0] col_out;
    logic [11:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    int         m_h [8];
    bit         m_own [8][8];
    bit         m_pl, m_pp, m_full;
    int         m_moves;
    logic [5:0] m_onoff;
    logic [2:0] m_col;

    column_drop_ctrl dut (
        .i_clk          (clk),
        .i_resetn       (resetn),
        .i_new_game     (new_game),
        .i_drop_req     (drop_req),
        .i_drop_col     (drop_col),
        .o_busy         (busy),
        .o_drop_done    (done),
        .o_drop_reject  (rej),
        .o_onoff_val    (onoff),
        .o_drop_col_out (col_out),
        .o_piece_player (pp),
        .o_player       (player),
        .o_board_full   (full),
        .i_rd_col       (rd_col),
        .i_rd_row       (rd_row),
        .o_rd_occupied  (rd_occ),
        .o_rd_player    (rd_pl)
    );

    always #5 clk = ~clk;
    assign obs = {onoff, col_out, pp, player, full};

    function automatic logic [11:0] exp_state();
        return {m_onoff, m_col, m_pp, m_pl, m_full};
    endfunction

    task automatic model_reset();
        foreach (m_h[c]) m_h[c] = 0;
        foreach (m_own[c, r]) m_own[c][r] = 1'b0;
        m_pl = 0; m_pp = 0; m_full = 0; m_moves = 0; m_onoff = '0; m_col = '0;
    endtask

    task automatic model_drop(input int col, output bit ok);
        ok = (col < 7) && (m_h[col] < 6);
        if (ok) begin
            m_own[col][m_h[col]] = m_pl;
            m_h[col]++;
            m_moves++;
            m_onoff = 6'((1 << m_h[col]) - 1);
            m_col   = 3'(col);
            m_pp    = m_pl;
            m_pl    = !m_pl;
            m_full  = (m_moves == 42);
        end
    endtask

    // issues one request (optionally re-requesting while busy) and records pulse cycles relative to the sampling edge
    task automatic do_drop(input int col, input bit spam, output int dk, output int rk,
                           output logic [5:0] bv, output int nd, output int nr);
        dk = 0; rk = 0; nd = 0; nr = 0; bv = '0;
        drop_req = 1'b1;
        drop_col = 3'(col);
        @(posedge clk);
        #1 drop_req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bv[k-1] = busy;
            if (done) begin nd++; if (dk == 0) dk = k; end
            if (rej)  begin nr++; if (rk == 0) rk = k; end
            if (spam && k <= 2) begin
                drop_req = 1'b1;
                drop_col = 3'(col + 1);
            end else drop_req = 1'b0;
        end
    endtask

    task automatic clear_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int dk, rk, nd, nr, cnt;
        logic [5:0] bv;
        do_drop(1, 0, dk, rk, bv, nd, nr);
        do_drop(1, 0, dk, rk, bv, nd, nr);
        resetn = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({obs, busy, done, rej} !== 15'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got state=%h busy=%b done=%b rej=%b, required all 0", obs, busy, done, rej);
        end
        resetn = 1'b1;
        @(negedge clk);
        cnt = 0;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++) begin
                rd_col = 3'(c); rd_row = 3'(r); #1;
                cnt += int'(rd_occ) + int'(rd_pl);
            end
        n_checks++;
        if (cnt != 0) begin
            n_errors++;
            $display("FAIL reset_cells: got %0d set read bits, required 0", cnt);
        end
        model_reset();
    endtask

    task automatic test_single_drop();
        int dk, rk, nd, nr;
        logic [5:0] bv;
        bit ok;
        do_drop(3, 0, dk, rk, bv, nd, nr);
        model_drop(3, ok);
        n_checks++;
        if (dk !== 3 || rk !== 0 || nd + nr !== 1 || bv !== 6'b000111) begin
            n_errors++;
            $display("FAIL single_timing: done_k=%0d rej_k=%0d pulses=%0d busy=%b, required done_k=3 rej_k=0 pulses=1 busy=000111", dk, rk, nd + nr, bv);
        end
        n_checks++;
        if (obs !== exp_state() || obs !== {6'b000001, 3'd3, 1'b0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL single_state: got %h required %h", obs, exp_state());
        end
    endtask

    task automatic test_column_fill();
        int dk, rk, nd, nr;
        logic [5:0] bv;
        bit ok;
        clear_game();
        for (int i = 0; i < 7; i++) begin
            do_drop(0, 0, dk, rk, bv, nd, nr);
            model_drop(0, ok);
            n_checks++;
            if (dk !== (ok ? 3 : 0) || rk !== (ok ? 0 : 2) || nd + nr !== 1 || bv !== (ok ? 6'b000111 : 6'b000011)) begin
                n_errors++;
                $display("FAIL colfill_timing drop=%0d: done_k=%0d rej_k=%0d pulses=%0d busy=%b, required done_k=%0d rej_k=%0d pulses=1", i, dk, rk, nd + nr, bv, ok ? 3 : 0, ok ? 0 : 2);
            end
            n_checks++;
            if (obs !== exp_state()) begin
                n_errors++;
                $display("FAIL colfill_state drop=%0d: got %h required %h", i, obs, exp_state());
            end
        end
    endtask

    task automatic test_reject_and_busy();
        int dk, rk, nd, nr, c;
        logic [5:0] bv;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            c = (i == 0) ? 7 : 4;
            do_drop(c, i == 1, dk, rk, bv, nd, nr);
            model_drop(c, ok);
            n_checks++;
            if (dk !== (ok ? 3 : 0) || rk !== (ok ? 0 : 2) || nd + nr !== 1 || bv !== (ok ? 6'b000111 : 6'b000011)) begin
                n_errors++;
                $display("FAIL rejbusy_timing col=%0d: done_k=%0d rej_k=%0d pulses=%0d busy=%b, required done_k=%0d rej_k=%0d pulses=1", c, dk, rk, nd + nr, bv, ok ? 3 : 0, ok ? 0 : 2);
            end
            n_checks++;
            if (obs !== exp_state()) begin
                n_errors++;
                $display("FAIL rejbusy_state col=%0d: got %h required %h", c, obs, exp_state());
            end
        end
    endtask

    task automatic test_fill_board();
        int dk, rk, nd, nr, c;
        logic [5:0] bv;
        bit ok;
        clear_game();
        for (int i = 0; i < 50; i++) begin
            c = (i < 42) ? i / 6 : i - 42;
            do_drop(c, 0, dk, rk, bv, nd, nr);
            model_drop(c, ok);
            n_checks++;
            if (dk !== (ok ? 3 : 0) || rk !== (ok ? 0 : 2) || nd + nr !== 1 || bv !== (ok ? 6'b000111 : 6'b000011)) begin
                n_errors++;
                $display("FAIL fullboard_timing drop=%0d: done_k=%0d rej_k=%0d pulses=%0d busy=%b, required done_k=%0d rej_k=%0d pulses=1", i, dk, rk, nd + nr, bv, ok ? 3 : 0, ok ? 0 : 2);
            end
            n_checks++;
            if (obs !== exp_state()) begin
                n_errors++;
                $display("FAIL fullboard_state drop=%0d: got %h required %h", i, obs, exp_state());
            end
        end
    endtask

    task automatic test_new_game_abort();
        int dk, rk, nd, nr, cnt;
        logic [5:0] bv;
        bit ok;
        clear_game();
        for (int i = 0; i < 2; i++) begin
            do_drop(5, 0, dk, rk, bv, nd, nr);
            model_drop(5, ok);
        end
        drop_req = 1'b1; drop_col = 3'd5;
        @(posedge clk);
        #1 drop_req = 1'b0;
        @(posedge clk);
        #1 new_game = 1'b1;
        @(posedge clk);
        #1 new_game = 1'b0;
        nd = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            nd += int'(done) + int'(rej);
        end
        model_reset();
        n_checks++;
        if (nd != 0 || {obs, busy} !== 13'b0) begin
            n_errors++;
            $display("FAIL abort_outputs: pulses=%0d state=%h busy=%b, required 0 pulses and all 0", nd, obs, busy);
        end
        cnt = 0;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++) begin
                rd_col = 3'(c); rd_row = 3'(r); #1;
                cnt += int'(rd_occ);
            end
        n_checks++;
        if (cnt != 0) begin
            n_errors++;
            $display("FAIL abort_cells: got %0d occupied cells, required 0", cnt);
        end
    endtask

    task automatic test_read_port();
        int dk, rk, nd, nr;
        logic [5:0] bv;
        bit ok;
        int tc [5] = '{2, 2, 2, 2, 7};
        int tr [5] = '{1, 2, 0, 6, 0};
        bit to [5] = '{1, 0, 1, 0, 0};
        bit tp [5] = '{1, 0, 0, 0, 0};
        clear_game();
        for (int i = 0; i < 2; i++) begin
            do_drop(2, 0, dk, rk, bv, nd, nr);
            model_drop(2, ok);
        end
        for (int i = 0; i < 5; i++) begin
            rd_col = 3'(tc[i]); rd_row = 3'(tr[i]); #1;
            n_checks++;
            if (rd_occ !== to[i] || rd_pl !== tp[i]) begin
                n_errors++;
                $display("FAIL read_cell c=%0d r=%0d: got occ=%b pl=%b required occ=%b pl=%b", tc[i], tr[i], rd_occ, rd_pl, to[i], tp[i]);
            end
        end
    endtask

    task automatic test_random();
        int dk, rk, nd, nr, c;
        logic [5:0] bv;
        bit ok, s, eo, ep;
        clear_game();
        for (int i = 0; i < 80; i++) begin
            c = $urandom_range(0, 7);
            s = ($urandom_range(0, 3) == 0);
            do_drop(c, s, dk, rk, bv, nd, nr);
            model_drop(c, ok);
            n_checks++;
            if (dk !== (ok ? 3 : 0) || rk !== (ok ? 0 : 2) || nd + nr !== 1 || bv !== (ok ? 6'b000111 : 6'b000011)) begin
                n_errors++;
                $display("FAIL random_timing drop=%0d col=%0d: done_k=%0d rej_k=%0d pulses=%0d busy=%b, required done_k=%0d rej_k=%0d pulses=1", i, c, dk, rk, nd + nr, bv, ok ? 3 : 0, ok ? 0 : 2);
            end
            n_checks++;
            if (obs !== exp_state()) begin
                n_errors++;
                $display("FAIL random_state drop=%0d col=%0d: got %h required %h", i, c, obs, exp_state());
            end
        end
        for (int cc = 0; cc < 8; cc++)
            for (int r = 0; r < 8; r++) begin
                rd_col = 3'(cc); rd_row = 3'(r); #1;
                eo = (r < m_h[cc]);
                ep = eo && m_own[cc][r];
                n_checks++;
                if (rd_occ !== eo || rd_pl !== ep) begin
                    n_errors++;
                    $display("FAIL random_cell c=%0d r=%0d: got occ=%b pl=%b required occ=%b pl=%b", cc, r, rd_occ, rd_pl, eo, ep);
                end
            end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_drop();
        test_column_fill();
        test_reject_and_busy();
        test_fill_board();
        test_new_game_abort();
        test_read_port();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/column_drop_ctrl.md
# column_drop_ctrl

Column occupancy and turn controller for the Connect Four board. Accepts a drop request for a column, rejects it if the column is full or out of range, otherwise stacks a piece for the current player and publishes that column's updated 6-bit occupancy thermometer (`onoff_val`). The VGA row finder sits directly downstream and converts `onoff_val` to the screen row. Also owns the player turn, the move count and a cell read port for drawing and win checking.

## Interface
- `NUM_COLS`, 7, board columns; column index width is 3 bits.
- `NUM_ROWS`, 6, board rows; occupancy thermometer width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `new_game`  in  1  synchronous board clear; priority below `resetn`, above all else.
- `drop_req`  in  1  request to drop into `drop_col`; sampled only in IDLE.
- `drop_col`  in  3  requested column, 0 = leftmost.
- `busy`  out  1  high in every state except IDLE.
- `drop_done`  out  1  one-cycle pulse: piece placed.
- `drop_reject`  out  1  one-cycle pulse: request refused.
- `onoff_val`  out  6  occupancy of the last placed column; bit 0 = bottom row; held until the next `drop_done`.
- `drop_col_out`  out  3  column of the last placed piece, held with `onoff_val`.
- `piece_player`  out  1  owner of the last placed piece, held with `onoff_val`.
- `player`  out  1  player whose turn it is; 0 = player 1.
- `board_full`  out  1  high once 42 pieces are placed.
- `rd_col`  in  3  cell read column.
- `rd_row`  in  3  cell read row; 0 = bottom.
- `rd_occupied`  out  1  combinational: cell is filled; 0 for out-of-range addresses.
- `rd_player`  out  1  combinational: cell owner; 0 when the cell is empty.

## Operation
- Storage: per column, a 6-bit occupancy thermometer `occ[c]` and a 6-bit owner vector `own[c]`. Thermometer values are only 000000, 000001, … 111111.
- FSM states: IDLE, CHECK, WRITE, DONE, REJECT.
- IDLE: on `drop_req` = 1, latch `drop_col` and go to CHECK. Otherwise stay in IDLE.
- CHECK: go to REJECT if the latched column ≥ `NUM_COLS` or `occ[col][5]` = 1. Otherwise go to WRITE.
- WRITE:
  - `own[col][k]` ← `player`, where k = number of ones in `occ[col]`.
  - `occ[col]` ← {`occ[col][4:0]`, 1}.
  - Increment the 6-bit move count.
  - Go to DONE.
- DONE:
  - Assert `drop_done`.
  - Load `onoff_val` = new `occ[col]`, `drop_col_out` = col, `piece_player` = `player`.
  - Toggle `player`.
  - Set `board_full` when the move count = 42.
  - Go to IDLE.
- REJECT: assert `drop_reject`. `player`, `onoff_val` and storage are unchanged. Go to IDLE.
- `drop_req` while busy is ignored. It is not queued.
- `new_game` or `resetn` = 0 (reset has priority if both are active):
  - All storage, `player`, move count and outputs return to zero.
  - FSM returns to IDLE.
  - Any operation in flight is aborted with no pulse.
- Reset values: all outputs 0; FSM in IDLE.

## Timing
- `drop_req` sampled at edge N, valid drop → `drop_done` high during cycle N+3; `onoff_val` is valid from that cycle onward.
- Invalid drop → `drop_reject` high during cycle N+2.
- `busy` is high from cycle N+1 through the pulse cycle. A new request is accepted at the first edge after `busy` falls.
- `player` toggles on the edge that ends DONE.
- Read port is combinational from storage. A written cell becomes visible on the edge that ends WRITE.

## Structure
- Shared package / include `connect4_defs`: `NUM_COLS`, `NUM_ROWS`, `MAX_MOVES` = 42, FSM state encodings, `PLAYER1` = 0, `PLAYER2` = 1.
- Sub-module `column_stack`, one instance per column (generate loop).
  - Holds `occ` and `own`.
  - Inputs: push enable, player.
  - Outputs: `occ`, `full`, `own`.
- Top level holds the FSM, the turn/move counters and the read mux.

## Test plan
- Reset, then drop column 3: `drop_done` at N+3; `onoff_val` = 000001, `drop_col_out` = 3, `piece_player` = 0; `player` becomes 1.
- Six drops into column 0, then a seventh: `onoff_val` steps 000001 → 111111 with alternating `piece_player`; the seventh drop gives `drop_reject` at N+2; `player` and `onoff_val` unchanged.
- Drop into column 7: `drop_reject`, no storage change. Pulse `drop_req` while `busy`: ignored, exactly one `drop_done`.
- Fill all 42 cells: `board_full` rises on the 42nd `drop_done`; every further drop is rejected.
- Assert `new_game` during WRITE: no `drop_done`; all outputs 0; `rd_occupied` = 0 for every cell.
- After drops P1→col 2 and P2→col 2: `rd_col` = 2, `rd_row` = 1 gives `rd_occupied` = 1, `rd_player` = 1; `rd_row` = 2 gives 0, 0.
